// File: rtl/float_hist_ctrl.sv
// float_hist_ctrl: time-shares one 16-bit to 11-bit float converter between
// the DQ (FLOATA) and SR (FLOATB) conversions of a G.726 sample and shifts the
// results into the predictor history registers DQ1..DQ6 and SR1..SR2.
module float_hist_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] DQ,
  input  logic [15:0] SR,
  output logic        busy,
  output logic        done,
  output logic        ovr,
  output logic [10:0] DQ1,
  output logic [10:0] DQ2,
  output logic [10:0] DQ3,
  output logic [10:0] DQ4,
  output logic [10:0] DQ5,
  output logic [10:0] DQ6,
  output logic [10:0] SR1,
  output logic [10:0] SR2
);

  // +0 with MANT 32: the value the predictor histories start from
  localparam logic [10:0] HIST_RESET = 11'h020;

  typedef enum logic [1:0] {
    IDLE,
    CONV_DQ,
    CONV_SR,
    UPDATE
  } state_t;

  state_t state;
  state_t next_state;

  // Sample captured at the start edge; DQ/SR need not stay valid afterwards
  logic [15:0] dq_hold;
  logic [15:0] sr_hold;

  // Converted results waiting for the history shift
  logic [10:0] dq_f;
  logic [10:0] sr_f;

  // FSM control strobes
  logic load_hold;
  logic load_dq_f;
  logic load_sr_f;
  logic shift_hist;
  logic sel_sr;
  logic overrun;

  // Shared converter datapath
  logic        conv_sign;
  logic [14:0] conv_mag;
  logic [14:0] sr_neg_mag;
  logic [3:0]  conv_exp;
  logic [5:0]  conv_mant;
  logic [10:0] conv_out;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode; a start outside IDLE only flags overrun
  always_comb begin
    next_state = state;
    load_hold  = 1'b0;
    load_dq_f  = 1'b0;
    load_sr_f  = 1'b0;
    shift_hist = 1'b0;
    sel_sr     = 1'b0;
    overrun    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_hold  = 1'b1;
          next_state = CONV_DQ;
        end
      end
      CONV_DQ: begin
        load_dq_f  = 1'b1;
        overrun    = start;
        next_state = CONV_SR;
      end
      CONV_SR: begin
        sel_sr     = 1'b1;
        load_sr_f  = 1'b1;
        overrun    = start;
        next_state = UPDATE;
      end
      UPDATE: begin
        shift_hist = 1'b1;
        overrun    = start;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Magnitude of a negative SR, reduced to 15 bits (-32768 folds to 0)
  assign sr_neg_mag = 15'd0 - sr_hold[14:0];

  // Select sign and magnitude for whichever operand is being converted
  always_comb begin
    if (sel_sr) begin
      conv_sign = sr_hold[15];
      conv_mag  = sr_hold[15] ? sr_neg_mag : sr_hold[14:0];
    end else begin
      conv_sign = dq_hold[15];
      conv_mag  = dq_hold[14:0];
    end
  end

  // Exponent is one more than the position of the leading one
  always_comb begin
    conv_exp = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (conv_mag[i]) begin
        conv_exp = i[3:0] + 4'd1;
      end
    end
  end

  // Normalize to a 6-bit mantissa by truncation; zero maps to MANT 32
  always_comb begin
    if (conv_mag == 15'd0) begin
      conv_mant = 6'd32;
    end else begin
      conv_mant = 6'(({conv_mag, 6'b000000}) >> conv_exp);
    end
    conv_out = {conv_sign, conv_exp, conv_mant};
  end

  // Capture the incoming sample only when a new one is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      dq_hold <= '0;
      sr_hold <= '0;
    end else if (load_hold) begin
      dq_hold <= DQ;
      sr_hold <= SR;
    end
  end

  // Park each converter result until the history update
  always_ff @(posedge clk) begin
    if (reset) begin
      dq_f <= '0;
      sr_f <= '0;
    end else begin
      if (load_dq_f) begin
        dq_f <= conv_out;
      end
      if (load_sr_f) begin
        sr_f <= conv_out;
      end
    end
  end

  // Shift the new floats into the predictor delay lines, newest first
  always_ff @(posedge clk) begin
    if (reset) begin
      DQ1 <= HIST_RESET;
      DQ2 <= HIST_RESET;
      DQ3 <= HIST_RESET;
      DQ4 <= HIST_RESET;
      DQ5 <= HIST_RESET;
      DQ6 <= HIST_RESET;
      SR1 <= HIST_RESET;
      SR2 <= HIST_RESET;
    end else if (shift_hist) begin
      DQ6 <= DQ5;
      DQ5 <= DQ4;
      DQ4 <= DQ3;
      DQ3 <= DQ2;
      DQ2 <= DQ1;
      DQ1 <= dq_f;
      SR2 <= SR1;
      SR1 <= sr_f;
    end
  end

  // Registered status: busy follows the next state, done marks the update
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= shift_hist;
      ovr  <= ovr | overrun;
    end
  end

endmodule

// File: tb/tb_float_hist_ctrl.sv
// tb_float_hist_ctrl: randomized self-checking bench for float_hist_ctrl with
// an arithmetic reference model of the float format and history lines.
module tb_float_hist_ctrl;

  logic        test_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dq_in;
  logic [15:0] sr_in;
  logic        busy;
  logic        done;
  logic        ovr;
  logic [10:0] dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2;

  logic [10:0] obs_dq [6];
  logic [10:0] obs_sr [2];
  logic [10:0] exp_dq [6];
  logic [10:0] exp_sr [2];

  int vectors     = 0;
  int miscompares = 0;
  int done_count  = 0;
  int exp_done    = 0;

  float_hist_ctrl dut (
    .clk   (test_clk),
    .reset (reset),
    .start (start),
    .DQ    (dq_in),
    .SR    (sr_in),
    .busy  (busy),
    .done  (done),
    .ovr   (ovr),
    .DQ1   (dq1),
    .DQ2   (dq2),
    .DQ3   (dq3),
    .DQ4   (dq4),
    .DQ5   (dq5),
    .DQ6   (dq6),
    .SR1   (sr1),
    .SR2   (sr2)
  );

  assign obs_dq[0] = dq1;
  assign obs_dq[1] = dq2;
  assign obs_dq[2] = dq3;
  assign obs_dq[3] = dq4;
  assign obs_dq[4] = dq5;
  assign obs_dq[5] = dq6;
  assign obs_sr[0] = sr1;
  assign obs_sr[1] = sr2;

  // Free-running clock
  always #5 test_clk = ~test_clk;

  // Count every done pulse independently of the per-sample checks
  always @(posedge test_clk) begin
    #1;
    if (done) done_count++;
  end

  // Float of a sign and magnitude computed straight from the format rules
  function automatic logic [10:0] float_of(input logic sign, input int mag);
    int e;
    int m;
    if (mag == 0) return {sign, 4'd0, 6'd32};
    e = 0;
    while ((1 << e) <= mag) e++;
    m = (mag * 64) / (1 << e);
    return {sign, e[3:0], m[5:0]};
  endfunction

  function automatic logic [10:0] dq_model(input logic [15:0] d);
    return float_of(d[15], int'(d[14:0]));
  endfunction

  function automatic logic [10:0] sr_model(input logic [15:0] s);
    int v;
    int mag;
    v = int'(s);
    if (s[15]) v = v - 65536;
    mag = (v < 0) ? -v : v;
    mag = mag % 32768;
    return float_of(s[15], mag);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) exp_dq[i] = 11'h020;
    for (int i = 0; i < 2; i++) exp_sr[i] = 11'h020;
  endtask

  task automatic model_push(input logic [15:0] d, input logic [15:0] s);
    for (int i = 5; i > 0; i--) exp_dq[i] = exp_dq[i-1];
    exp_dq[0] = dq_model(d);
    exp_sr[1] = exp_sr[0];
    exp_sr[0] = sr_model(s);
    exp_done++;
  endtask

  task automatic check_hist(input string tag);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("%s_dq%0d", tag, i + 1), 16'(obs_dq[i]), 16'(exp_dq[i]));
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("%s_sr%0d", tag, i + 1), 16'(obs_sr[i]), 16'(exp_sr[i]));
  endtask

  // Called at a negedge; returns at the negedge of the done cycle so the
  // next call lands in that cycle and keeps the 4-clock sample period
  task automatic applyStimulus(input string tag, input logic [15:0] d,
                               input logic [15:0] s);
    start = 1'b1;
    dq_in = d;
    sr_in = s;
    for (int c = 0; c < 3; c++) begin
      @(negedge test_clk);
      start = 1'b0;
      dq_in = 16'($urandom);
      sr_in = 16'($urandom);
      checkOutput($sformatf("%s_busy%0d", tag, c), 16'(busy), 16'd1);
      checkOutput($sformatf("%s_nodone%0d", tag, c), 16'(done), 16'd0);
    end
    @(negedge test_clk);
    model_push(d, s);
    checkOutput({tag, "_done"}, 16'(done), 16'd1);
    checkOutput({tag, "_idle"}, 16'(busy), 16'd0);
    check_hist(tag);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    start = 1'b0;
    repeat (cycles) @(negedge test_clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] pick_value();
    case ($urandom_range(0, 4))
      0: return 16'h0000;
      1: return 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 1)) << 15);
      2: return 16'(16'hFFFF - $urandom_range(0, 15));
      3: return {1'($urandom_range(0, 1)), 15'h7FFF - 15'($urandom_range(0, 3))};
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] td [12];
    logic [15:0] ts [12];
    int base;

    reset = 1'b1;
    start = 1'b0;
    dq_in = '0;
    sr_in = '0;
    model_reset();

    // Reset values after a 2-cycle reset
    do_reset(2);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_done", 16'(done), 16'd0);
    checkOutput("rst_ovr", 16'(ovr), 16'd0);
    check_hist("rst");

    // Reset mid-sample at E2: sample discarded, no done afterwards
    applyStimulus("pre", 16'h1234, 16'h4321);
    start = 1'b1;
    dq_in = 16'h0ABC;
    sr_in = 16'hF00F;
    @(negedge test_clk);
    start = 1'b0;
    @(negedge test_clk);
    do_reset(2);
    checkOutput("abort_busy", 16'(busy), 16'd0);
    checkOutput("abort_done", 16'(done), 16'd0);
    checkOutput("abort_ovr", 16'(ovr), 16'd0);
    check_hist("abort");
    for (int c = 0; c < 4; c++) begin
      @(negedge test_clk);
      checkOutput($sformatf("abort_quiet%0d", c), 16'(done), 16'd0);
    end
    check_hist("abort_hold");

    // Conversion corners with the known results
    applyStimulus("c_dq0", 16'h0000, 16'($urandom));
    checkOutput("c_dq0_val", 16'(dq1), 16'h020);
    applyStimulus("c_dq8005", 16'h8005, 16'($urandom));
    checkOutput("c_dq8005_val", 16'(dq1), 16'h4E8);
    applyStimulus("c_dq7fff", 16'h7FFF, 16'($urandom));
    checkOutput("c_dq7fff_val", 16'(dq1), 16'h3FF);
    applyStimulus("c_srffff", 16'($urandom), 16'hFFFF);
    checkOutput("c_srffff_val", 16'(sr1), 16'h460);
    applyStimulus("c_sr0100", 16'($urandom), 16'h0100);
    checkOutput("c_sr0100_val", 16'(sr1), 16'h260);
    applyStimulus("c_sr8000", 16'($urandom), 16'h8000);
    checkOutput("c_sr8000_val", 16'(sr1), 16'h420);
    checkOutput("c_ovr", 16'(ovr), 16'd0);

    // History shift: seven back-to-back samples DQ = k, SR = -k
    for (int k = 1; k <= 7; k++)
      applyStimulus($sformatf("hist%0d", k), 16'(k), 16'(65536 - k));
    checkOutput("hist_dq1", 16'(dq1), 16'(float_of(1'b0, 7)));
    checkOutput("hist_dq6", 16'(dq6), 16'(float_of(1'b0, 2)));
    checkOutput("hist_sr2", 16'(sr2), 16'(float_of(1'b1, 6)));
    checkOutput("hist_ovr", 16'(ovr), 16'd0);

    // Overrun: second start at E2 is ignored and sets ovr
    start = 1'b1;
    dq_in = 16'h0042;
    sr_in = 16'hFF00;
    @(negedge test_clk);
    start = 1'b0;
    dq_in = '0;
    sr_in = '0;
    @(negedge test_clk);
    start = 1'b1;
    dq_in = 16'h7ABC;
    sr_in = 16'h1357;
    @(negedge test_clk);
    start = 1'b0;
    checkOutput("ovr_set", 16'(ovr), 16'd1);
    checkOutput("ovr_nodone", 16'(done), 16'd0);
    @(negedge test_clk);
    model_push(16'h0042, 16'hFF00);
    checkOutput("ovr_done", 16'(done), 16'd1);
    check_hist("ovr");
    for (int c = 0; c < 4; c++) begin
      @(negedge test_clk);
      checkOutput($sformatf("ovr_single%0d", c), 16'(done), 16'd0);
    end
    checkOutput("ovr_sticky", 16'(ovr), 16'd1);
    applyStimulus("ovr_next", 16'h0011, 16'h0022);
    checkOutput("ovr_sticky2", 16'(ovr), 16'd1);
    do_reset(1);
    checkOutput("ovr_clear", 16'(ovr), 16'd0);

    // Throughput: start held high 12 cycles, accepted every 4th edge
    for (int i = 0; i < 12; i++) begin
      td[i] = pick_value();
      ts[i] = pick_value();
    end
    for (int i = 0; i < 12; i++) begin
      start = 1'b1;
      dq_in = td[i];
      sr_in = ts[i];
      @(negedge test_clk);
      if (i % 4 == 3) begin
        base = i - 3;
        model_push(td[base], ts[base]);
        checkOutput($sformatf("tp_done%0d", i), 16'(done), 16'd1);
        checkOutput($sformatf("tp_busy%0d", i), 16'(busy), 16'd0);
        check_hist($sformatf("tp%0d", i));
      end else begin
        checkOutput($sformatf("tp_done%0d", i), 16'(done), 16'd0);
        checkOutput($sformatf("tp_busy%0d", i), 16'(busy), 16'd1);
      end
    end
    start = 1'b0;
    checkOutput("tp_ovr", 16'(ovr), 16'd1);
    do_reset(2);
    check_hist("tp_rst");

    // Randomized stream with occasional idle gaps
    for (int n = 0; n < 150; n++) begin
      applyStimulus($sformatf("s%0d", n), pick_value(), pick_value());
      repeat ($urandom_range(0, 2)) begin
        @(negedge test_clk);
        checkOutput($sformatf("s%0d_gap", n), 16'(done), 16'd0);
      end
    end
    checkOutput("stream_ovr", 16'(ovr), 16'd0);

    @(negedge test_clk);
    checkOutput("done_total", 16'(done_count), 16'(exp_done));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
